if_decd: RTL and testbench

IF_DECD -- requirements
Module: if_decd

---
 rtl/if_decd.sv | 135 +++++++++++++
 tb/tb_if_decd.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/if_decd.sv
// ============================================================================
// Module   : if_decd
// Brief    : Instruction fetch / decode front end with next-PC and retire count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_decd #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic        clk,
    input  logic        clr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        PCWr,
    input  logic [1:0]  nPCOp,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [6:0]  decdOp,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic        ir_valid,
    output logic [31:0] retired
);

    typedef enum logic [0:0] {
        S_FETCH  = 1'b0,
        S_DECODE = 1'b1
    } state_t;

    localparam logic [6:0] c_DEC_ADDU = 7'b1000011;
    localparam logic [6:0] c_DEC_SUBU = 7'b1000111;
    localparam logic [6:0] c_DEC_ORI  = 7'b0011010;
    localparam logic [6:0] c_DEC_LW   = 7'b1000110;
    localparam logic [6:0] c_DEC_SW   = 7'b1010110;
    localparam logic [6:0] c_DEC_BEQ  = 7'b0001000;
    localparam logic [6:0] c_DEC_J    = 7'b0000100;
    localparam logic [31:0] c_STEP    = 32'(WORD_BYTES);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] retired_q;
    logic        ir_valid_q;

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] npc_d;
    logic [6:0]  dec_d;

    assign pc4    = pc_q + c_STEP;
    assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    always_comb begin
        npc_d = pc4;
        case (nPCOp)
            2'd1:    npc_d = zero ? (pc4 + br_off) : pc4;
            2'd2:    npc_d = {pc4[31:28], ir_q[25:0], 2'b00};
            default: npc_d = pc4;
        endcase
    end

    // Decode is masked while the IR does not hold a live instruction.
    always_comb begin
        dec_d = 7'b0000000;
        if (ir_valid_q) begin
            case (ir_q[31:26])
                6'h00: begin
                    if (ir_q[5:0] == 6'h21)
                        dec_d = c_DEC_ADDU;
                    else if (ir_q[5:0] == 6'h23)
                        dec_d = c_DEC_SUBU;
                end
                6'h0D:   dec_d = c_DEC_ORI;
                6'h23:   dec_d = c_DEC_LW;
                6'h2B:   dec_d = c_DEC_SW;
                6'h04:   dec_d = c_DEC_BEQ;
                6'h02:   dec_d = c_DEC_J;
                default: dec_d = 7'b0000000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= 32'h0;
            retired_q  <= 32'h0;
            ir_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_q       <= imem_rdata;
                        ir_valid_q <= 1'b1;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (PCWr) begin
                        pc_q       <= npc_d;
                        retired_q  <= retired_q + 32'd1;
                        ir_valid_q <= 1'b0;
                        state_q    <= S_FETCH;
                    end
                end
                default: begin
                    state_q    <= S_FETCH;
                    ir_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Request is gated by clr so memory sees no fetch while reset is held.
    assign imem_req  = (state_q == S_FETCH) && !clr;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign decdOp    = dec_d;
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign imm16     = ir_q[15:0];
    assign ir_valid  = ir_valid_q;
    assign retired   = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_if_decd.sv
// ============================================================================
// Module   : tb_if_decd
// Brief    : Self-checking bench for if_decd using a directed instruction table
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_decd;

    logic        clk;
    logic        clr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        PCWr;
    logic [1:0]  nPCOp;
    logic        zero;
    logic [31:0] pc;
    logic [6:0]  decdOp;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic        ir_valid;
    logic [31:0] retired;

    int n_cmp;
    int n_bad;

    if_decd #(
        .RESET_PC   (32'h0000_3000),
        .WORD_BYTES (4)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .PCWr       (PCWr),
        .nPCOp      (nPCOp),
        .zero       (zero),
        .pc         (pc),
        .decdOp     (decdOp),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm16      (imm16),
        .ir_valid   (ir_valid),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [1:0]  op;
        logic        z;
        int          dly;
        logic [6:0]  dec;
        logic [4:0]  f_rs;
        logic [4:0]  f_rt;
        logic [4:0]  f_rd;
        logic [15:0] imm;
        logic [31:0] pc0;
        logic [31:0] pc1;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clr = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        PCWr = 1'b0;
        nPCOp = 2'd0;
        zero = 1'b0;

        //              ir            op  z  dly dec         rs     rt     rd     imm       pc0           pc1
        tv[0]  = '{32'h3401_1234, 2'd0, 1'b0, 3, 7'b0011010, 5'd0, 5'd1, 5'd2,  16'h1234, 32'h0000_3000, 32'h0000_3004};
        tv[1]  = '{32'h0000_0821, 2'd0, 1'b0, 0, 7'b1000011, 5'd0, 5'd0, 5'd1,  16'h0821, 32'h0000_3004, 32'h0000_3008};
        tv[2]  = '{32'h1000_FFFE, 2'd1, 1'b1, 1, 7'b0001000, 5'd0, 5'd0, 5'd31, 16'hFFFE, 32'h0000_3008, 32'h0000_3004};
        tv[3]  = '{32'h0062_2023, 2'd0, 1'b0, 2, 7'b1000111, 5'd3, 5'd2, 5'd4,  16'h2023, 32'h0000_3004, 32'h0000_3008};
        tv[4]  = '{32'h1000_FFFE, 2'd1, 1'b0, 0, 7'b0001000, 5'd0, 5'd0, 5'd31, 16'hFFFE, 32'h0000_3008, 32'h0000_300C};
        tv[5]  = '{32'hAC22_0008, 2'd3, 1'b1, 1, 7'b1010110, 5'd1, 5'd2, 5'd0,  16'h0008, 32'h0000_300C, 32'h0000_3010};
        tv[6]  = '{32'h0800_0C00, 2'd2, 1'b0, 0, 7'b0000100, 5'd0, 5'd0, 5'd1,  16'h0C00, 32'h0000_3010, 32'h0000_3000};
        tv[7]  = '{32'h8C43_FFFC, 2'd1, 1'b1, 2, 7'b1000110, 5'd2, 5'd3, 5'd31, 16'hFFFC, 32'h0000_3000, 32'h0000_2FF4};
        tv[8]  = '{32'hFC00_0000, 2'd0, 1'b0, 0, 7'b0000000, 5'd0, 5'd0, 5'd0,  16'h0000, 32'h0000_2FF4, 32'h0000_2FF8};
        tv[9]  = '{32'h3C01_1234, 2'd0, 1'b1, 1, 7'b0000000, 5'd0, 5'd1, 5'd2,  16'h1234, 32'h0000_2FF8, 32'h0000_2FFC};
        tv[10] = '{32'h0000_0820, 2'd0, 1'b0, 0, 7'b0000000, 5'd0, 5'd0, 5'd1,  16'h0820, 32'h0000_2FFC, 32'h0000_3000};
        tv[11] = '{32'h0800_0000, 2'd2, 1'b0, 1, 7'b0000100, 5'd0, 5'd0, 5'd0,  16'h0000, 32'h0000_3000, 32'h0000_0000};
        tv[12] = '{32'h1000_FFFE, 2'd1, 1'b1, 0, 7'b0001000, 5'd0, 5'd0, 5'd31, 16'hFFFE, 32'h0000_0000, 32'hFFFF_FFFC};
        tv[13] = '{32'h0000_0821, 2'd0, 1'b0, 0, 7'b1000011, 5'd0, 5'd0, 5'd1,  16'h0821, 32'hFFFF_FFFC, 32'h0000_0000};

        // Reset state while clr is held.
        tick();
        tick();
        chk("rst_req_low", {63'd0, imem_req}, 64'd0);
        chk("rst_state", {pc, retired}, {32'h0000_3000, 32'h0});
        chk("rst_valid_dec", {56'd0, ir_valid, decdOp}, 64'd0);
        clr = 1'b0;
        #1;
        chk("rst_req_after", {63'd0, imem_req}, 64'd1);

        for (int i = 0; i < 14; i++) begin
            chk($sformatf("v%0d_fetch", i), {30'd0, imem_req, ir_valid, imem_addr},
                {30'd0, 1'b1, 1'b0, tv[i].pc0});
            for (int d = 0; d < tv[i].dly; d++) begin
                tick();
                chk($sformatf("v%0d_wait%0d", i, d), {31'd0, imem_req, imem_addr},
                    {31'd0, 1'b1, tv[i].pc0});
            end
            imem_ack = 1'b1;
            imem_rdata = tv[i].ir;
            tick();
            imem_ack = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            chk($sformatf("v%0d_decode", i),
                {6'd0, imem_req, ir_valid, decdOp, tv[i].f_rs == rs, rt, rd, imm16},
                {6'd0, 1'b0, 1'b1, tv[i].dec, 1'b1, tv[i].f_rt, tv[i].f_rd, tv[i].imm});
            chk($sformatf("v%0d_pc_hold", i), {32'd0, pc}, {32'd0, tv[i].pc0});

            // Acknowledge during DECODE must not disturb the held IR.
            imem_ack = 1'b1;
            imem_rdata = ~tv[i].ir;
            tick();
            imem_ack = 1'b0;
            chk($sformatf("v%0d_ack_ign", i), {32'd0, ir_valid, decdOp, imm16, rt, rd},
                {32'd0, 1'b1, tv[i].dec, tv[i].imm, tv[i].f_rt, tv[i].f_rd});

            PCWr = 1'b1;
            nPCOp = tv[i].op;
            zero = tv[i].z;
            tick();
            PCWr = 1'b0;
            nPCOp = 2'd0;
            zero = 1'b0;
            chk($sformatf("v%0d_npc", i), {32'd0, pc}, {32'd0, tv[i].pc1});
            chk($sformatf("v%0d_retire", i), {23'd0, imem_req, ir_valid, decdOp, retired},
                {23'd0, 1'b1, 1'b0, 7'd0, 32'(i + 1)});
        end

        // PCWr while fetching has no effect.
        PCWr = 1'b1;
        nPCOp = 2'd2;
        tick();
        tick();
        PCWr = 1'b0;
        nPCOp = 2'd0;
        chk("pcwr_fetch_ign", {pc, retired}, {32'h0, 32'd14});
        chk("pcwr_fetch_state", {62'd0, imem_req, ir_valid}, {62'd0, 1'b1, 1'b0});

        // Asynchronous clr in the middle of DECODE.
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0821;
        tick();
        imem_ack = 1'b0;
        chk("pre_clr_decode", {56'd0, ir_valid, decdOp}, {56'd0, 1'b1, 7'b1000011});
        #2;
        clr = 1'b1;
        #1;
        chk("async_clr_state", {pc, retired}, {32'h0000_3000, 32'h0});
        chk("async_clr_flags", {55'd0, imem_req, ir_valid, decdOp}, 64'd0);

        // clr wins over coincident PCWr and imem_ack.
        PCWr = 1'b1;
        nPCOp = 2'd1;
        zero = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'h3401_1234;
        tick();
        chk("clr_wins", {pc, retired}, {32'h0000_3000, 32'h0});
        chk("clr_wins_flags", {55'd0, imem_req, ir_valid, decdOp}, 64'd0);
        PCWr = 1'b0;
        nPCOp = 2'd0;
        zero = 1'b0;
        imem_ack = 1'b0;
        clr = 1'b0;
        #1;
        chk("post_clr_req", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h0000_3000});
        tick();
        chk("post_clr_fetch", {62'd0, imem_req, ir_valid}, {62'd0, 1'b1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
